bus_arbiter_n: RTL

Parametrised N-master / M-slave bus arbiter for the serial system bus, the successor to the fixed two-master arbiter. Each requesting master shifts in a serial slave address. The block arbitrates among requesters using fixed or round-robin priority, then drives grant lines, the master-mux code and the slave select. It supports one level of split transaction per bus, and it sits between the masters' request/address lines and the bus multiplexers.

---
 rtl/bus_arbiter_n_pkg.sv | 26 ++
 rtl/bus_arbiter_n_if.sv | 31 +++
 rtl/bus_arbiter_n_pick.sv | 29 ++
 rtl/bus_arbiter_n.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_n_pkg.sv
// rtl/bus_arbiter_n_pkg.sv - shared state, split-context and grant-code helpers for bus_arbiter_n
package bus_arb_pkg;

  localparam int OWNER_W = 3;
  localparam int SLAVE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    BUSY,
    SPLIT_IDLE,
    SPLIT_ADDR,
    SPLIT_BUSY
  } arb_state_t;

  // Wide enough for the largest configuration; the arbiter truncates on use.
  typedef struct packed {
    logic [OWNER_W-1:0] owner;
    logic [SLAVE_W-1:0] slave;
  } split_ctx_t;

  function automatic logic [OWNER_W:0] grant_code(input logic [OWNER_W-1:0] idx);
    return {1'b0, idx} + {{OWNER_W{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/bus_arbiter_n_if.sv
// rtl/bus_arbiter_n_if.sv - request/address/grant bundle between masters and bus_arbiter_n
interface bus_arbiter_n_if #(
  parameter int NUM_M   = 2,
  parameter int NUM_S   = 3,
  parameter int SADDR_W = 2,
  parameter int GW      = $clog2(NUM_M + 1)
);

  logic [NUM_M-1:0]   M_RQST;
  logic [NUM_M-1:0]   M_SADDR;
  logic               tx_done;
  logic [NUM_S-1:0]   S_SPLIT_EN;
  logic [NUM_M-1:0]   M_GRANT;
  logic [GW-1:0]      bus_grant;
  logic [SADDR_W-1:0] slave_select;
  logic               ARB_BUSY;
  logic               BUS_BUSY;
  logic               ADDR_ERR;
  logic               SPLIT_DENY;

  modport master (
    output M_RQST, M_SADDR, tx_done, S_SPLIT_EN,
    input  M_GRANT, bus_grant, slave_select, ARB_BUSY, BUS_BUSY, ADDR_ERR, SPLIT_DENY
  );

  modport slave (
    input  M_RQST, M_SADDR, tx_done, S_SPLIT_EN,
    output M_GRANT, bus_grant, slave_select, ARB_BUSY, BUS_BUSY, ADDR_ERR, SPLIT_DENY
  );

endinterface

// File: rtl/bus_arbiter_n_pick.sv
// rtl/bus_arbiter_n_pick.sv - combinational winner pick, fixed or round-robin from rr_ptr
module rr_arbiter_pick #(
  parameter  int NUM_M   = 2,
  parameter  int RR_MODE = 1,
  localparam int IW      = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [IW-1:0]    rr_ptr_i,
  output logic [IW-1:0]    idx_o,
  output logic             valid_o
);

  int cand;

  // Walk from the farthest offset down so the nearest requester is written last.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      cand = (RR_MODE != 0) ? ((int'(rr_ptr_i) + i) % NUM_M) : i;
      if (req_i[IW'(cand)]) begin
        idx_o   = IW'(cand);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_n.sv
// rtl/bus_arbiter_n.sv - N-master/M-slave serial-address bus arbiter with one split level
module bus_arbiter_n
  import bus_arb_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int NUM_S   = 3,
  parameter int SADDR_W = 2,
  parameter int RR_MODE = 1,
  parameter int GW      = $clog2(NUM_M + 1)
) (
  input  logic           MASTER_CLK,
  input  logic           MASTER_RST,
  bus_arbiter_n_if.slave bus
);

  localparam int IW = $clog2(NUM_M);
  localparam int CW = $clog2(SADDR_W + 1);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      winner_q, winner_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [SADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  split_ctx_t         ctx_q, ctx_d;
  logic [NUM_M-1:0]   grant_q, grant_d;
  logic [GW-1:0]      code_q, code_d;
  logic [SADDR_W-1:0] sel_q, sel_d;
  logic               arb_busy_q, arb_busy_d;
  logic               bus_busy_q, bus_busy_d;
  logic               addr_err_q, addr_err_d;
  logic               split_deny_q, split_deny_d;

  logic [NUM_M-1:0]   elig;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic               sel_split;
  logic               ctx_split;
  logic               addr_ok;
  logic               in_split;

  rr_arbiter_pick #(
    .NUM_M   (NUM_M),
    .RR_MODE (RR_MODE)
  ) u_pick (
    .req_i    (elig),
    .rr_ptr_i (rr_ptr_q),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  // The suspended owner may not compete while its slave holds the split.
  always_comb begin
    elig = bus.M_RQST;
    if (state_q == SPLIT_IDLE) elig[IW'(ctx_q.owner)] = 1'b0;
  end

  always_comb begin
    sel_split = 1'b0;
    ctx_split = 1'b0;
    for (int k = 0; k < NUM_S; k++) begin
      if (sel_q == SADDR_W'(k + 1) && bus.S_SPLIT_EN[k]) sel_split = 1'b1;
      if (ctx_q.slave == SLAVE_W'(k + 1) && bus.S_SPLIT_EN[k]) ctx_split = 1'b1;
    end
  end

  assign addr_ok  = (addr_q != '0) && (int'(addr_q) <= NUM_S);
  assign in_split = (state_q == SPLIT_ADDR);

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    rr_ptr_d     = rr_ptr_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    ctx_d        = ctx_q;
    grant_d      = grant_q;
    code_d       = code_q;
    sel_d        = sel_q;
    arb_busy_d   = arb_busy_q;
    bus_busy_d   = bus_busy_q;
    addr_err_d   = 1'b0;
    split_deny_d = 1'b0;

    case (state_q)
      IDLE, SPLIT_IDLE: begin
        if (state_q == SPLIT_IDLE && !ctx_split) begin
          winner_d   = IW'(ctx_q.owner);
          grant_d    = NUM_M'(1) << IW'(ctx_q.owner);
          code_d     = GW'(grant_code(ctx_q.owner));
          sel_d      = SADDR_W'(ctx_q.slave);
          bus_busy_d = 1'b1;
          state_d    = BUSY;
        end else if (pick_valid) begin
          winner_d   = pick_idx;
          addr_d     = SADDR_W'(bus.M_SADDR[pick_idx]);
          cnt_d      = CW'(1);
          arb_busy_d = 1'b1;
          state_d    = (state_q == IDLE) ? ADDR : SPLIT_ADDR;
        end
      end

      ADDR, SPLIT_ADDR: begin
        if (!bus.M_RQST[winner_q]) begin
          arb_busy_d = 1'b0;
          state_d    = in_split ? SPLIT_IDLE : IDLE;
        end else if (cnt_q != CW'(SADDR_W)) begin
          addr_d = (addr_q << 1) | SADDR_W'(bus.M_SADDR[winner_q]);
          cnt_d  = cnt_q + CW'(1);
        end else begin
          arb_busy_d = 1'b0;
          if (in_split && SLAVE_W'(addr_q) == ctx_q.slave) begin
            split_deny_d = 1'b1;
            state_d      = SPLIT_IDLE;
          end else if (!addr_ok) begin
            addr_err_d = 1'b1;
            state_d    = in_split ? SPLIT_IDLE : IDLE;
          end else begin
            grant_d    = NUM_M'(1) << winner_q;
            code_d     = GW'(grant_code(OWNER_W'(winner_q)));
            sel_d      = addr_q;
            bus_busy_d = 1'b1;
            rr_ptr_d   = (winner_q == IW'(NUM_M - 1)) ? '0 : winner_q + IW'(1);
            state_d    = in_split ? SPLIT_BUSY : BUSY;
          end
        end
      end

      BUSY: begin
        if (bus.tx_done) begin
          grant_d    = '0;
          code_d     = '0;
          sel_d      = '0;
          bus_busy_d = 1'b0;
          state_d    = IDLE;
        end else if (sel_split) begin
          ctx_d.owner = OWNER_W'(winner_q);
          ctx_d.slave = SLAVE_W'(sel_q);
          grant_d     = '0;
          code_d      = '0;
          sel_d       = '0;
          bus_busy_d  = 1'b0;
          state_d     = SPLIT_IDLE;
        end
      end

      // Return to the suspended owner even if its slave still splits; BUSY re-splits.
      SPLIT_BUSY: begin
        if (bus.tx_done) begin
          winner_d   = IW'(ctx_q.owner);
          grant_d    = NUM_M'(1) << IW'(ctx_q.owner);
          code_d     = GW'(grant_code(ctx_q.owner));
          sel_d      = SADDR_W'(ctx_q.slave);
          bus_busy_d = 1'b1;
          state_d    = BUSY;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MASTER_CLK or posedge MASTER_RST) begin
    if (MASTER_RST) begin
      state_q      <= IDLE;
      winner_q     <= '0;
      rr_ptr_q     <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      ctx_q        <= '0;
      grant_q      <= '0;
      code_q       <= '0;
      sel_q        <= '0;
      arb_busy_q   <= 1'b0;
      bus_busy_q   <= 1'b0;
      addr_err_q   <= 1'b0;
      split_deny_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      rr_ptr_q     <= rr_ptr_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      ctx_q        <= ctx_d;
      grant_q      <= grant_d;
      code_q       <= code_d;
      sel_q        <= sel_d;
      arb_busy_q   <= arb_busy_d;
      bus_busy_q   <= bus_busy_d;
      addr_err_q   <= addr_err_d;
      split_deny_q <= split_deny_d;
    end
  end

  assign bus.M_GRANT      = grant_q;
  assign bus.bus_grant    = code_q;
  assign bus.slave_select = sel_q;
  assign bus.ARB_BUSY     = arb_busy_q;
  assign bus.BUS_BUSY     = bus_busy_q;
  assign bus.ADDR_ERR     = addr_err_q;
  assign bus.SPLIT_DENY   = split_deny_q;

endmodule
